// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  typedef enum logic {EDGE = 1'b0, CENTER = 1'b1} mode_e;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Configuration/output bundle of pwm_multi; master drives the requests, slave is the PWM.
interface pwm_multi_if import pwm_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS
) ();

  logic                      io_inc;
  logic [WIDTH-1:0]          io_T;
  logic [CHANNELS*WIDTH-1:0] io_duty;
  logic                      io_center;
  logic                      io_load;
  logic [CHANNELS-1:0]       io_out;
  logic [WIDTH-1:0]          io_cont;
  logic                      io_wrap;

  modport master (
    output io_inc, io_T, io_duty, io_center, io_load,
    input  io_out, io_cont, io_wrap
  );

  modport slave (
    input  io_inc, io_T, io_duty, io_center, io_load,
    output io_out, io_cont, io_wrap
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared up / up-down counter with combinational period-end detection.
module pwm_timebase import pwm_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [WIDTH-1:0] period,
  input  mode_e            mode,
  output logic [WIDTH-1:0] cont,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cont;
  dir_e             r_dir;
  logic [WIDTH-1:0] w_top;
  logic             w_short;

  assign w_top   = period - ONE;
  assign w_short = (period <= ONE);
  assign cont    = r_cont;

  // Periods of 0 or 1 collapse to a counter parked at 0 that ends every cycle.
  always_comb begin
    wrap = 1'b0;
    if (!reset && inc) begin
      if (w_short)
        wrap = 1'b1;
      else if (mode == EDGE)
        wrap = (r_cont == w_top);
      else
        wrap = (r_cont == '0) && (r_dir == DOWN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cont <= '0;
      r_dir  <= UP;
    end else if (inc) begin
      if (wrap) begin
        r_cont <= '0;
        r_dir  <= UP;
      end else if (mode == EDGE) begin
        r_cont <= r_cont + ONE;
      end else if (r_dir == UP) begin
        // Top value is held for one extra cycle while turning around.
        if (r_cont == w_top)
          r_dir <= DOWN;
        else
          r_cont <= r_cont + ONE;
      end else begin
        r_cont <= r_cont - ONE;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM on one timebase; period/duty/mode changes are staged and applied at period end.
module pwm_multi import pwm_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS
) (
  input  logic        clock,
  input  logic        reset,
  pwm_multi_if.slave  bus
);

  logic [WIDTH-1:0]          r_T_a;
  logic [CHANNELS*WIDTH-1:0] r_duty_a;
  mode_e                     r_mode_a;
  logic [WIDTH-1:0]          r_T_s;
  logic [CHANNELS*WIDTH-1:0] r_duty_s;
  mode_e                     r_mode_s;
  logic                      r_pend;

  logic [WIDTH-1:0]          w_cont;
  logic                      w_wrap;
  mode_e                     w_mode_in;
  logic [CHANNELS-1:0]       w_out;

  assign w_mode_in = bus.io_center ? CENTER : EDGE;

  pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
    .clock  (clock),
    .reset  (reset),
    .inc    (bus.io_inc),
    .period (r_T_a),
    .mode   (r_mode_a),
    .cont   (w_cont),
    .wrap   (w_wrap)
  );

  // A load coinciding with period end bypasses staging; otherwise the staged set waits for it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_T_a    <= '0;
      r_duty_a <= '0;
      r_mode_a <= EDGE;
      r_T_s    <= '0;
      r_duty_s <= '0;
      r_mode_s <= EDGE;
      r_pend   <= 1'b0;
    end else begin
      if (bus.io_load) begin
        r_T_s    <= bus.io_T;
        r_duty_s <= bus.io_duty;
        r_mode_s <= w_mode_in;
      end
      if (w_wrap) begin
        if (bus.io_load) begin
          r_T_a    <= bus.io_T;
          r_duty_a <= bus.io_duty;
          r_mode_a <= w_mode_in;
        end else if (r_pend) begin
          r_T_a    <= r_T_s;
          r_duty_a <= r_duty_s;
          r_mode_a <= r_mode_s;
        end
        r_pend <= 1'b0;
      end else if (bus.io_load) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_out = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      w_out[i] = !reset && bus.io_inc && (w_cont < r_duty_a[i*WIDTH +: WIDTH]);
  end

  assign bus.io_out  = w_out;
  assign bus.io_cont = w_cont;
  assign bus.io_wrap = w_wrap;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi: vector table plus hand-written multi-cycle sequences.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_multi_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  pwm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic        rst;
    logic        inc;
    logic        load;
    logic [7:0]  t;
    logic [31:0] duty;
    logic        center;
    logic [3:0]  e_out;
    logic [7:0]  e_cont;
    logic        e_wrap;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic cycle(input logic r, input logic i, input logic l, input logic [7:0] t,
                       input logic [31:0] d, input logic c, input logic [3:0] eo,
                       input logic [7:0] ec, input logic ew, input string tag);
    @(posedge clk);
    #1;
    rst           = r;
    bus.io_inc    = i;
    bus.io_load   = l;
    bus.io_T      = t;
    bus.io_duty   = d;
    bus.io_center = c;
    @(negedge clk);
    chk($sformatf("%s.out@%0t", tag, $time), 32'(bus.io_out), 32'(eo));
    chk($sformatf("%s.cont@%0t", tag, $time), 32'(bus.io_cont), 32'(ec));
    chk($sformatf("%s.wrap@%0t", tag, $time), 32'(bus.io_wrap), 32'(ew));
  endtask

  function automatic logic [3:0] exp_out(input logic [7:0] cnt, input logic [31:0] d);
    logic [3:0] r;
    logic [31:0] dd;
    dd = d;
    for (int k = 0; k < 4; k++) r[k] = (cnt < dd[k*8 +: 8]);
    return r;
  endfunction

  // Edge-mode run with no load; junk on T/duty/center must not leak through.
  task automatic edge_run(input int unsigned start, input int unsigned n, input int unsigned t,
                          input logic [31:0] da, input string tag);
    for (int unsigned j = 0; j < n; j++) begin
      logic [7:0] cnt;
      cnt = 8'((start + j) % t);
      cycle(1'b0, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b1,
            exp_out(cnt, da), cnt, (32'(cnt) == t - 1), tag);
    end
  endtask

  task automatic center_run(input int unsigned n);
    logic [7:0] cseq[10];
    cseq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    for (int unsigned j = 0; j < n; j++) begin
      logic [7:0] cnt;
      cnt = cseq[j % 10];
      cycle(1'b0, 1'b1, 1'b0, 8'h5A, 32'h12345678, 1'b0,
            exp_out(cnt, 32'h0000_0200), cnt, ((j % 10) == 9), "center");
    end
  endtask

  initial begin
    bus.io_inc = 1'b0; bus.io_load = 1'b0; bus.io_T = '0;
    bus.io_duty = '0;  bus.io_center = 1'b0;

    //           rst  inc  load T      duty   ctr   out     cont   wrap
    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 8'd10, 32'd5, 1'b0, 4'b0000, 8'd0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0001, 8'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0001, 8'd1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0001, 8'd2, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0001, 8'd3, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0001, 8'd4, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd5, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd6, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd7, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd8, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0000, 8'd9, 1'b1};
    vt[13] = '{1'b0, 1'b1, 1'b0, 8'd0,  32'd0, 1'b0, 4'b0001, 8'd0, 1'b0};

    @(posedge clk);
    for (int i = 0; i < 14; i++)
      cycle(vt[i].rst, vt[i].inc, vt[i].load, vt[i].t, vt[i].duty, vt[i].center,
            vt[i].e_out, vt[i].e_cont, vt[i].e_wrap, $sformatf("vec%0d", i));

    // Mid-period load waits for the wrap; load on a wrap applies next cycle.
    cycle(1'b0, 1'b1, 1'b1, 8'd6, 32'h3, 1'b0, 4'b0001, 8'd1, 1'b0, "midload");
    edge_run(2, 8, 10, 32'h5, "old_period");
    edge_run(0, 5, 6, 32'h3, "new_period");
    cycle(1'b0, 1'b1, 1'b1, 8'd4, 32'h1, 1'b0, 4'b0000, 8'd5, 1'b1, "load_at_wrap");
    edge_run(0, 4, 4, 32'h1, "bypass_period");

    // Two staged loads, latest wins; then center mode T=5, duty1=2.
    cycle(1'b0, 1'b1, 1'b1, 8'd7, 32'h0000_0300, 1'b1, 4'b0001, 8'd0, 1'b0, "stage_first");
    cycle(1'b0, 1'b1, 1'b1, 8'd5, 32'h0000_0200, 1'b1, 4'b0000, 8'd1, 1'b0, "stage_latest");
    edge_run(2, 2, 4, 32'h1, "pre_center");
    center_run(19);

    // Duties 0, 3, 12 and 10 with T=10, loaded on the center wrap.
    cycle(1'b0, 1'b1, 1'b1, 8'd10, 32'h0A0C_0300, 1'b0, 4'b0010, 8'd0, 1'b1, "center_wrap_load");
    edge_run(0, 13, 10, 32'h0A0C_0300, "duty_mix");

    // Disabled: frozen counter, outputs low, staging still accepts a load (T=1).
    for (int j = 0; j < 4; j++)
      cycle(1'b0, 1'b0, (j == 1), 8'd1, 32'h1, 1'b0, 4'b0000, 8'd3, 1'b0, "inc_low");
    edge_run(3, 7, 10, 32'h0A0C_0300, "resume");
    for (int j = 0; j < 3; j++)
      cycle(1'b0, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b1, 4'b0001, 8'd0, 1'b1, "t1");
    cycle(1'b0, 1'b0, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b1, 4'b0000, 8'd0, 1'b0, "t1_inc_low");

    // Reset mid-period clears a pending load and aborts the period.
    cycle(1'b0, 1'b1, 1'b1, 8'd10, 32'h5, 1'b0, 4'b0001, 8'd0, 1'b1, "load_t10");
    edge_run(0, 5, 10, 32'h5, "pre_rst");
    cycle(1'b0, 1'b1, 1'b1, 8'd4, 32'h2, 1'b0, 4'b0000, 8'd5, 1'b0, "pend_before_rst");
    edge_run(6, 1, 10, 32'h5, "pre_rst6");
    cycle(1'b1, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 4'b0000, 8'd7, 1'b0, "rst_at_7");
    cycle(1'b1, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 4'b0000, 8'd0, 1'b0, "rst_hold");
    cycle(1'b0, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 4'b0000, 8'd0, 1'b1, "post_rst_wrap");
    cycle(1'b0, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 4'b0000, 8'd0, 1'b1, "no_pending");
    cycle(1'b0, 1'b0, 1'b1, 8'd3, 32'h2, 1'b0, 4'b0000, 8'd0, 1'b0, "load_inc_low");
    cycle(1'b0, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 4'b0000, 8'd0, 1'b1, "apply_pending");
    edge_run(0, 6, 3, 32'h2, "t3");

    // T=0: counter parked at 0, wrap every enabled cycle, duty 3 constant high.
    cycle(1'b0, 1'b1, 1'b1, 8'd0, 32'h3, 1'b0, 4'b0001, 8'd0, 1'b0, "load_t0_pend");
    edge_run(1, 2, 3, 32'h2, "t3_tail");
    for (int j = 0; j < 3; j++)
      cycle(1'b0, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 4'b0001, 8'd0, 1'b1, "t0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter WIDTH, default 8, bit width of period, duty and counter values.
REQ-002 Parameter CHANNELS, default 4, number of PWM outputs sharing one timebase.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_inc  input  1  count enable; when low, counter holds and all outputs are low.
REQ-006 io_T  input  WIDTH  requested period in counts.
REQ-007 io_duty  input  CHANNELS*WIDTH  requested per-channel duty; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 io_center  input  1  requested mode: 0 edge-aligned, 1 center-aligned.
REQ-009 io_load  input  1  request to stage io_T, io_duty and io_center for application at the next period end.
REQ-010 io_out  output  CHANNELS  PWM outputs.
REQ-011 io_cont  output  WIDTH  current counter value.
REQ-012 io_wrap  output  1  period-end indication, high for exactly the period-end cycle.

Function
REQ-013 Active registers T_a, duty_a[CHANNELS] and mode_a SHALL govern all counting and comparison; inputs SHALL NOT affect outputs except through them.
REQ-014 io_load high SHALL capture io_T, io_duty and io_center into staging registers and set a pending flag; a later load before application overwrites staging (latest wins).
REQ-015 At a period-end cycle (io_wrap high) with pending set, active registers SHALL take staging values on that edge, pending SHALL clear, and the counter SHALL restart at 0 counting up.
REQ-016 io_load and io_wrap high in the same cycle SHALL apply the current io_T/io_duty/io_center directly (bypass staging) on that edge.
REQ-017 Edge mode: counter counts 0,1,...,T_a-1 then 0; period-end cycle is cont==T_a-1 with io_inc high; period is T_a cycles.
REQ-018 Center mode: counter counts up 0..T_a-1, holds T_a-1 one cycle while switching to down, counts down to 0; period-end cycle is cont==0, direction down, io_inc high; the next cycle repeats 0 with direction up; period is 2*T_a cycles.
REQ-019 T_a of 0 or 1 SHALL hold the counter at 0, and every enabled cycle SHALL be a period-end cycle.
REQ-020 io_out[i] SHALL equal io_inc AND (cont < duty_a[i]), unsigned WIDTH-bit compare, in both modes.
REQ-021 duty_a[i]==0 SHALL yield constant low; duty_a[i] >= T_a SHALL yield constant high while enabled.
REQ-022 io_wrap SHALL be combinational from the counter, direction, T_a and io_inc, and SHALL be low while reset or io_inc is low.
REQ-023 io_inc low SHALL freeze counter, direction and active registers; staging and the pending flag still update on io_load.
REQ-024 io_cont SHALL equal the registered counter, without the io_inc gating.

Reset
REQ-025 While reset is high, on each clock edge: counter 0, direction up, T_a 0, duty_a all 0, mode_a edge, staging 0, pending 0.
REQ-026 io_out and io_wrap SHALL be 0 while reset is high; io_cont SHALL read 0 from the first edge after reset asserts.
REQ-027 Reset asserted mid-period SHALL abort the period with no wrap pulse; after release, T_a==0 makes the first enabled cycle a period end, so a pending load applies immediately.

Structure
REQ-028 Shared package pwm_pkg SHALL hold the mode enum (EDGE, CENTER), the direction enum (UP, DOWN) and default WIDTH/CHANNELS constants.
REQ-029 Counter, direction and period-end logic SHALL be one sub-module, pwm_timebase; compare, staging and load logic stay in pwm_multi.

Verification
REQ-030 Reset; io_load with T=10, duty0=5, edge mode, io_inc=1 -> io_cont 0..9 repeating, io_out[0] high at cont 0..4 and low at 5..9, io_wrap at cont 9.
REQ-031 Center mode, T=5, duty1=2 -> io_cont 0,1,2,3,4,4,3,2,1,0 repeating, io_out[1] high at the 0,1 and 1,0 positions (4 of 10 cycles), io_wrap at the down-count 0.
REQ-032 Mid-period io_load with T=6 while T_a=10 -> no change until the cont==9 wrap, then a 6-cycle period; io_load coinciding with the wrap -> new values take effect on the next cycle.
REQ-033 Duty values 0, 3 and 12 with T=10 on three channels -> constant low, 3-of-10 high, constant high; io_inc low for 4 cycles -> io_out all 0, io_cont frozen, no io_wrap.
REQ-034 Reset asserted at cont=7 -> io_cont 0 and io_out 0 after the next edge, no io_wrap; T=0 or T=1 loaded -> io_cont stays 0 and io_wrap high every enabled cycle.
